// File: rtl/iitb_decode_queue.sv
// iitb_decode_queue
// -----------------
// Buffers fetched IITB-25 instructions in a DEPTH-entry FIFO and decodes the
// head into a registered micro-op for the register-file/LSU issue stage.
// LM/SM can be expanded into one micro-op per selected register. flush_i
// discards everything in flight (branch redirect).
//
// Parameters
//   DEPTH         FIFO entries (power of two, >= 2)
//   EXPAND_MULTI  1: LM/SM expand into per-register micro-ops
//                 0: LM/SM leave as one micro-op, raw mask in imm_val_o[7:0]
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   instr_valid_i           fetch offers fetch_pc_i / fetch_instr_i
//   fetch_ready_o           FIFO has room (combinational, count < DEPTH)
//   flush_i                 drop FIFO, expansion and output micro-op
//   mem_stall_i             downstream stall, output register holds
//   opcode_valid_o          micro-op valid
//   opcode_pc_o             PC of the parent instruction
//   opcode_instr_o          raw word of the parent instruction
//   one_hot_o               one-hot opcode class (see OH_* below)
//   rd_idx_o/ra_idx_o/rb_idx_o  register indices
//   imm_val_o               extended immediate, or LM/SM offset 2*k
//   uop_last_o              last micro-op of the parent instruction
//
// one_hot_o bit assignment:
//   0 ADA  1 ADC  2 ADZ  3 AWC  4 ACA  5 ACC  6 ACZ  7 ACW
//   8 NDU  9 NDC 10 NDZ 11 NCU 12 NCC 13 NCZ
//  14 ADI 15 LLI 16 LW  17 SW  18 LM  19 SM
//  20 BEQ 21 BLT 22 BLE 23 JAL 24 JLR 25 JRI
// Undefined encodings decode to an all-zero one_hot_o.

module iitb_decode_queue #(
  parameter int DEPTH        = 4,
  parameter int EXPAND_MULTI = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_valid_i,
  input  logic [15:0] fetch_pc_i,
  input  logic [15:0] fetch_instr_i,
  output logic        fetch_ready_o,
  input  logic        flush_i,
  input  logic        mem_stall_i,
  output logic        opcode_valid_o,
  output logic [15:0] opcode_pc_o,
  output logic [15:0] opcode_instr_o,
  output logic [25:0] one_hot_o,
  output logic [2:0]  rd_idx_o,
  output logic [2:0]  ra_idx_o,
  output logic [2:0]  rb_idx_o,
  output logic [15:0] imm_val_o,
  output logic        uop_last_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [3:0] OP_ADI  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_LLI  = 4'b0011;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_LM   = 4'b0110;
  localparam logic [3:0] OP_SM   = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BLT  = 4'b1001;
  localparam logic [3:0] OP_BLE  = 4'b1010;
  localparam logic [3:0] OP_JAL  = 4'b1100;
  localparam logic [3:0] OP_JLR  = 4'b1101;
  localparam logic [3:0] OP_JRI  = 4'b1111;

  localparam logic [4:0] OH_ADA = 5'd0;
  localparam logic [4:0] OH_NDU = 5'd8;
  localparam logic [4:0] OH_ADI = 5'd14;
  localparam logic [4:0] OH_LLI = 5'd15;
  localparam logic [4:0] OH_LW  = 5'd16;
  localparam logic [4:0] OH_SW  = 5'd17;
  localparam logic [4:0] OH_LM  = 5'd18;
  localparam logic [4:0] OH_SM  = 5'd19;
  localparam logic [4:0] OH_BEQ = 5'd20;
  localparam logic [4:0] OH_BLT = 5'd21;
  localparam logic [4:0] OH_BLE = 5'd22;
  localparam logic [4:0] OH_JAL = 5'd23;
  localparam logic [4:0] OH_JLR = 5'd24;
  localparam logic [4:0] OH_JRI = 5'd25;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_e;

  // FIFO storage and bookkeeping
  logic [15:0]      pc_mem_q    [DEPTH];
  logic [15:0]      pc_mem_d    [DEPTH];
  logic [15:0]      instr_mem_q [DEPTH];
  logic [15:0]      instr_mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Expansion state
  state_e     state_q, state_d;
  logic [7:0] mask_q, mask_d;
  logic [2:0] k_q, k_d;

  // Output micro-op register
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_pc_q, out_pc_d;
  logic [15:0] out_instr_q, out_instr_d;
  logic [25:0] out_one_hot_q, out_one_hot_d;
  logic [2:0]  out_rd_q, out_rd_d;
  logic [2:0]  out_ra_q, out_ra_d;
  logic [2:0]  out_rb_q, out_rb_d;
  logic [15:0] out_imm_q, out_imm_d;
  logic        out_last_q, out_last_d;

  // Combinational helpers
  logic        fetch_ready;
  logic        push;
  logic        pop;
  logic        advance;
  logic        head_avail;
  logic [15:0] head_pc;
  logic [15:0] head_instr;
  logic [3:0]  head_op;
  logic        head_is_multi;
  logic        expand_head;
  logic [1:0]  cz_rank;
  logic [4:0]  oh_idx;
  logic        oh_ok;
  logic [25:0] dec_one_hot;
  logic [2:0]  dec_rd, dec_ra, dec_rb;
  logic [15:0] dec_imm;
  logic [7:0]  cur_mask;
  logic [2:0]  cur_k;
  logic [2:0]  sel_bit;
  logic [2:0]  sel_reg;
  logic [7:0]  rem_mask;

  assign fetch_ready   = (count_q < DEPTH_C);
  assign fetch_ready_o = fetch_ready;

  // A push during flush is dropped; when full there is no bypass even if the
  // head pops in the same cycle.
  assign push       = instr_valid_i && fetch_ready && !flush_i;
  assign head_avail = (count_q != '0);
  assign advance    = !flush_i && (!out_valid_q || !mem_stall_i);

  assign head_pc       = pc_mem_q[rd_ptr_q];
  assign head_instr    = instr_mem_q[rd_ptr_q];
  assign head_op       = head_instr[15:12];
  assign head_is_multi = (head_op == OP_LM) || (head_op == OP_SM);
  assign expand_head   = (EXPAND_MULTI != 0) && head_is_multi;

  // CZ = 00/10/01/11 maps to A/C/Z/W variants, i.e. rank = {cz[0], cz[1]}.
  assign cz_rank = {head_instr[0], head_instr[1]};

  // Plain decode of the FIFO head (no LM/SM expansion applied).
  always_comb begin
    oh_idx  = '0;
    oh_ok   = 1'b1;
    dec_rd  = '0;
    dec_ra  = '0;
    dec_rb  = '0;
    dec_imm = '0;
    case (head_op)
      OP_ADD: begin
        oh_idx = OH_ADA + {2'b00, head_instr[2], cz_rank};
        dec_ra = head_instr[11:9];
        dec_rb = head_instr[8:6];
        dec_rd = head_instr[5:3];
      end
      OP_NAND: begin
        // NAND has no carry-with-zero form, so CZ=11 is undefined.
        oh_ok  = (head_instr[1:0] != 2'b11);
        oh_idx = OH_NDU + (head_instr[2] ? 5'd3 : 5'd0) + {3'b000, cz_rank};
        dec_ra = head_instr[11:9];
        dec_rb = head_instr[8:6];
        dec_rd = head_instr[5:3];
      end
      OP_ADI: begin
        oh_idx  = OH_ADI;
        dec_ra  = head_instr[11:9];
        dec_rd  = head_instr[8:6];
        dec_imm = {{10{head_instr[5]}}, head_instr[5:0]};
      end
      OP_LLI: begin
        oh_idx  = OH_LLI;
        dec_rd  = head_instr[11:9];
        dec_imm = {7'b0, head_instr[8:0]};
      end
      OP_LW: begin
        oh_idx  = OH_LW;
        dec_rd  = head_instr[11:9];
        dec_ra  = head_instr[8:6];
        dec_imm = {{10{head_instr[5]}}, head_instr[5:0]};
      end
      OP_SW: begin
        oh_idx  = OH_SW;
        dec_rb  = head_instr[11:9];
        dec_ra  = head_instr[8:6];
        dec_imm = {{10{head_instr[5]}}, head_instr[5:0]};
      end
      OP_LM, OP_SM: begin
        oh_idx  = (head_op == OP_LM) ? OH_LM : OH_SM;
        dec_ra  = head_instr[11:9];
        dec_imm = {8'b0, head_instr[7:0]};
      end
      OP_BEQ, OP_BLT, OP_BLE: begin
        oh_idx  = (head_op == OP_BEQ) ? OH_BEQ :
                  (head_op == OP_BLT) ? OH_BLT : OH_BLE;
        dec_ra  = head_instr[11:9];
        dec_rb  = head_instr[8:6];
        dec_imm = {{10{head_instr[5]}}, head_instr[5:0]};
      end
      OP_JAL: begin
        oh_idx  = OH_JAL;
        dec_rd  = head_instr[11:9];
        dec_imm = {{7{head_instr[8]}}, head_instr[8:0]};
      end
      OP_JLR: begin
        oh_idx = OH_JLR;
        dec_rd = head_instr[11:9];
        dec_ra = head_instr[8:6];
      end
      OP_JRI: begin
        oh_idx  = OH_JRI;
        dec_ra  = head_instr[11:9];
        dec_imm = {{7{head_instr[8]}}, head_instr[8:0]};
      end
      default: oh_ok = 1'b0;
    endcase
    dec_one_hot = oh_ok ? (26'd1 << oh_idx) : '0;
  end

  // In IDLE the head's own mask is used, so the first micro-op leaves in
  // the same cycle the instruction is first seen.
  assign cur_mask = (state_q == ST_EXPAND) ? mask_q : head_instr[7:0];
  assign cur_k    = (state_q == ST_EXPAND) ? k_q : 3'd0;

  // Mask bit 7 is R0, so the highest set bit has priority.
  always_comb begin
    sel_bit = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (cur_mask[i]) sel_bit = 3'(i);
    end
  end

  assign sel_reg  = 3'd7 - sel_bit;
  assign rem_mask = cur_mask & ~(8'd1 << sel_bit);

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: a zero mask or the final bit both return to IDLE.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else if (advance && head_avail && expand_head) begin
      state_d = (rem_mask == '0) ? ST_IDLE : ST_EXPAND;
    end
  end

  // FSM outputs: micro-op register contents, pop and working-mask updates.
  always_comb begin
    pop           = 1'b0;
    mask_d        = mask_q;
    k_d           = k_q;
    out_valid_d   = out_valid_q;
    out_pc_d      = out_pc_q;
    out_instr_d   = out_instr_q;
    out_one_hot_d = out_one_hot_q;
    out_rd_d      = out_rd_q;
    out_ra_d      = out_ra_q;
    out_rb_d      = out_rb_q;
    out_imm_d     = out_imm_q;
    out_last_d    = out_last_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (advance) begin
      out_valid_d = 1'b0;
      if (head_avail) begin
        if (expand_head) begin
          if (cur_mask == '0) begin
            pop = 1'b1;
          end else begin
            out_valid_d   = 1'b1;
            out_pc_d      = head_pc;
            out_instr_d   = head_instr;
            out_one_hot_d = dec_one_hot;
            out_ra_d      = head_instr[11:9];
            out_rd_d      = (head_op == OP_LM) ? sel_reg : 3'd0;
            out_rb_d      = (head_op == OP_SM) ? sel_reg : 3'd0;
            out_imm_d     = {12'b0, cur_k, 1'b0};
            out_last_d    = (rem_mask == '0);
            pop           = (rem_mask == '0);
            mask_d        = rem_mask;
            k_d           = cur_k + 3'd1;
          end
        end else begin
          out_valid_d   = 1'b1;
          out_pc_d      = head_pc;
          out_instr_d   = head_instr;
          out_one_hot_d = dec_one_hot;
          out_rd_d      = dec_rd;
          out_ra_d      = dec_ra;
          out_rb_d      = dec_rb;
          out_imm_d     = dec_imm;
          out_last_d    = 1'b1;
          pop           = 1'b1;
        end
      end
    end
  end

  // FIFO pointer, count and storage update.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]    = fetch_pc_i;
        instr_mem_d[wr_ptr_q] = fetch_instr_i;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk_i) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      mask_q        <= '0;
      k_q           <= '0;
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_instr_q   <= '0;
      out_one_hot_q <= '0;
      out_rd_q      <= '0;
      out_ra_q      <= '0;
      out_rb_q      <= '0;
      out_imm_q     <= '0;
      out_last_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      mask_q        <= mask_d;
      k_q           <= k_d;
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      out_instr_q   <= out_instr_d;
      out_one_hot_q <= out_one_hot_d;
      out_rd_q      <= out_rd_d;
      out_ra_q      <= out_ra_d;
      out_rb_q      <= out_rb_d;
      out_imm_q     <= out_imm_d;
      out_last_q    <= out_last_d;
    end
  end

  assign opcode_valid_o = out_valid_q;
  assign opcode_pc_o    = out_pc_q;
  assign opcode_instr_o = out_instr_q;
  assign one_hot_o      = out_one_hot_q;
  assign rd_idx_o       = out_rd_q;
  assign ra_idx_o       = out_ra_q;
  assign rb_idx_o       = out_rb_q;
  assign imm_val_o      = out_imm_q;
  assign uop_last_o     = out_last_q;

endmodule

// File: tb/tb_iitb_decode_queue.sv
// Directed bench for iitb_decode_queue (DEPTH=4, EXPAND_MULTI=1).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.

module tb_iitb_decode_queue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_valid_i;
  logic [15:0] fetch_pc_i;
  logic [15:0] fetch_instr_i;
  logic        fetch_ready_o;
  logic        flush_i;
  logic        mem_stall_i;
  logic        opcode_valid_o;
  logic [15:0] opcode_pc_o;
  logic [15:0] opcode_instr_o;
  logic [25:0] one_hot_o;
  logic [2:0]  rd_idx_o;
  logic [2:0]  ra_idx_o;
  logic [2:0]  rb_idx_o;
  logic [15:0] imm_val_o;
  logic        uop_last_o;

  int check_count = 0;
  int pass_count  = 0;

  iitb_decode_queue #(
    .DEPTH        (4),
    .EXPAND_MULTI (1)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .instr_valid_i  (instr_valid_i),
    .fetch_pc_i     (fetch_pc_i),
    .fetch_instr_i  (fetch_instr_i),
    .fetch_ready_o  (fetch_ready_o),
    .flush_i        (flush_i),
    .mem_stall_i    (mem_stall_i),
    .opcode_valid_o (opcode_valid_o),
    .opcode_pc_o    (opcode_pc_o),
    .opcode_instr_o (opcode_instr_o),
    .one_hot_o      (one_hot_o),
    .rd_idx_o       (rd_idx_o),
    .ra_idx_o       (ra_idx_o),
    .rb_idx_o       (rb_idx_o),
    .imm_val_o      (imm_val_o),
    .uop_last_o     (uop_last_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] pc,
                               input logic [15:0] instr, input logic flush,
                               input logic stall);
    instr_valid_i = valid;
    fetch_pc_i    = pc;
    fetch_instr_i = instr;
    flush_i       = flush;
    mem_stall_i   = stall;
  endtask

  task automatic waitCycle();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]  lm_rd [4];
    logic [15:0] ch_pc [4];
    logic [15:0] ch_instr [4];
    logic [15:0] ch_imm [4];
    logic [25:0] ch_oh [4];
    int accepted;
    int seen;
    int push_idx;
    int got;
    logic did_push;

    lm_rd    = '{3'd1, 3'd2, 3'd3, 3'd6};
    ch_pc    = '{16'h0030, 16'h0032, 16'h0034, 16'h0036};
    ch_instr = '{16'hABBD, 16'h570F, 16'hC1FF, 16'h3FFF};
    ch_imm   = '{16'hFFFD, 16'h000F, 16'hFFFF, 16'h01FF};
    ch_oh    = '{26'h040_0000, 26'h002_0000, 26'h080_0000, 26'h000_8000};

    // Reset with a push offered: everything must stay zero.
    rst_i = 1'b1;
    applyStimulus(1'b1, 16'h1234, 16'h3A01, 1'b0, 1'b0);
    waitCycle();
    waitCycle();
    waitCycle();
    checkOutput("rst_valid", 32'(opcode_valid_o), 32'd0);
    checkOutput("rst_last", 32'(uop_last_o), 32'd0);
    checkOutput("rst_pc", 32'(opcode_pc_o), 32'd0);
    checkOutput("rst_instr", 32'(opcode_instr_o), 32'd0);
    checkOutput("rst_one_hot", 32'(one_hot_o), 32'd0);
    checkOutput("rst_idx", 32'({rd_idx_o, ra_idx_o, rb_idx_o}), 32'd0);
    checkOutput("rst_imm", 32'(imm_val_o), 32'd0);
    rst_i = 1'b0;
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    #1;
    checkOutput("rst_ready", 32'(fetch_ready_o), 32'd1);
    waitCycle();
    checkOutput("rst_no_push", 32'(opcode_valid_o), 32'd0);

    // Single LLI: valid one cycle after the push edge.
    applyStimulus(1'b1, 16'h002A, 16'h3A01, 1'b0, 1'b0);
    waitCycle();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    checkOutput("lli_not_yet", 32'(opcode_valid_o), 32'd0);
    waitCycle();
    checkOutput("lli_valid", 32'(opcode_valid_o), 32'd1);
    checkOutput("lli_pc", 32'(opcode_pc_o), 32'h002A);
    checkOutput("lli_instr", 32'(opcode_instr_o), 32'h3A01);
    checkOutput("lli_rd", 32'(rd_idx_o), 32'd5);
    checkOutput("lli_imm", 32'(imm_val_o), 32'h0001);
    checkOutput("lli_last", 32'(uop_last_o), 32'd1);
    checkOutput("lli_one_hot", 32'(one_hot_o), 32'h0000_8000);
    waitCycle();
    checkOutput("lli_drain", 32'(opcode_valid_o), 32'd0);

    // LM 0x6472: R1, R2, R3, R6 from base R2.
    applyStimulus(1'b1, 16'h002C, 16'h6472, 1'b0, 1'b0);
    waitCycle();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++) begin
      waitCycle();
      checkOutput($sformatf("lm%0d_valid", j), 32'(opcode_valid_o), 32'd1);
      checkOutput($sformatf("lm%0d_rd", j), 32'(rd_idx_o), 32'(lm_rd[j]));
      checkOutput($sformatf("lm%0d_ra", j), 32'(ra_idx_o), 32'd2);
      checkOutput($sformatf("lm%0d_imm", j), 32'(imm_val_o), 32'(2 * j));
      checkOutput($sformatf("lm%0d_last", j), 32'(uop_last_o), (j == 3) ? 32'd1 : 32'd0);
      checkOutput($sformatf("lm%0d_pc", j), 32'(opcode_pc_o), 32'h002C);
      if (j == 0) checkOutput("lm_one_hot", 32'(one_hot_o), 32'h0004_0000);
    end
    waitCycle();
    checkOutput("lm_drain", 32'(opcode_valid_o), 32'd0);

    // Back-to-back BLE / SW / JAL / LLI: extension cases.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) applyStimulus(1'b1, ch_pc[i], ch_instr[i], 1'b0, 1'b0);
      else       applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      waitCycle();
      if (i > 0) begin
        checkOutput($sformatf("chain%0d_pc", i - 1), 32'(opcode_pc_o), 32'(ch_pc[i - 1]));
        checkOutput($sformatf("chain%0d_imm", i - 1), 32'(imm_val_o), 32'(ch_imm[i - 1]));
        checkOutput($sformatf("chain%0d_one_hot", i - 1), 32'(one_hot_o), 32'(ch_oh[i - 1]));
        if (i == 1) begin
          checkOutput("ble_ra", 32'(ra_idx_o), 32'd5);
          checkOutput("ble_rb", 32'(rb_idx_o), 32'd6);
        end
        if (i == 4) checkOutput("lli_hi_rd", 32'(rd_idx_o), 32'd7);
      end
    end
    waitCycle();
    checkOutput("chain_drain", 32'(opcode_valid_o), 32'd0);

    // Stall: offer 7, expect 5 accepted (4 in FIFO + output register).
    accepted = 0;
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(1'b1, 16'h0100 + 16'(2 * k), 16'h3000 | 16'(k), 1'b0, 1'b1);
      if (fetch_ready_o) accepted++;
      waitCycle();
    end
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    checkOutput("stall_accepted", 32'(accepted), 32'd5);
    checkOutput("stall_ready_low", 32'(fetch_ready_o), 32'd0);
    checkOutput("stall_head_pc", 32'(opcode_pc_o), 32'h0102);
    waitCycle();
    checkOutput("stall_frozen_pc", 32'(opcode_pc_o), 32'h0102);
    checkOutput("stall_frozen_valid", 32'(opcode_valid_o), 32'd1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    for (int k = 2; k <= 5; k++) begin
      waitCycle();
      checkOutput($sformatf("release%0d_valid", k), 32'(opcode_valid_o), 32'd1);
      checkOutput($sformatf("release%0d_pc", k), 32'(opcode_pc_o), 32'h0100 + 32'(2 * k));
      checkOutput($sformatf("release%0d_imm", k), 32'(imm_val_o), 32'(k));
      if (k == 2) checkOutput("release_ready", 32'(fetch_ready_o), 32'd1);
    end
    waitCycle();
    checkOutput("release_drain", 32'(opcode_valid_o), 32'd0);

    // Flush on 2nd micro-op of SM 0x76E0 (base R3, R0..R2) with 3 LLIs queued.
    applyStimulus(1'b1, 16'h0140, 16'h76E0, 1'b0, 1'b1);
    waitCycle();
    applyStimulus(1'b1, 16'h0142, 16'h3001, 1'b0, 1'b1);
    waitCycle();
    applyStimulus(1'b1, 16'h0144, 16'h3002, 1'b0, 1'b1);
    waitCycle();
    applyStimulus(1'b1, 16'h0146, 16'h3003, 1'b0, 1'b1);
    waitCycle();
    checkOutput("sm0_rb", 32'(rb_idx_o), 32'd0);
    checkOutput("sm0_ra", 32'(ra_idx_o), 32'd3);
    checkOutput("sm0_last", 32'(uop_last_o), 32'd0);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    waitCycle();
    checkOutput("sm1_rb", 32'(rb_idx_o), 32'd1);
    checkOutput("sm1_imm", 32'(imm_val_o), 32'd2);
    checkOutput("sm1_pc", 32'(opcode_pc_o), 32'h0140);
    // Flush together with a stall and a push that must be dropped.
    applyStimulus(1'b1, 16'h01F0, 16'h3E07, 1'b1, 1'b1);
    waitCycle();
    checkOutput("flush_valid", 32'(opcode_valid_o), 32'd0);
    checkOutput("flush_ready", 32'(fetch_ready_o), 32'd1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      waitCycle();
      if (opcode_valid_o) seen++;
    end
    checkOutput("flush_no_leftover", 32'(seen), 32'd0);
    applyStimulus(1'b1, 16'h0150, 16'h3C03, 1'b0, 1'b0);
    waitCycle();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    waitCycle();
    checkOutput("post_flush_pc", 32'(opcode_pc_o), 32'h0150);
    checkOutput("post_flush_rd", 32'(rd_idx_o), 32'd6);
    checkOutput("post_flush_last", 32'(uop_last_o), 32'd1);
    waitCycle();

    // Zero-mask LM followed by 10 LLIs: pointers wrap, LM is silent.
    push_idx = 0;
    got      = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (push_idx == 0)
        applyStimulus(1'b1, 16'h0200, 16'h6000, 1'b0, 1'b0);
      else if (push_idx <= 10)
        applyStimulus(1'b1, 16'h0200 + 16'(2 * push_idx), 16'h3000 | 16'(push_idx), 1'b0, 1'b0);
      else
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      did_push = instr_valid_i && fetch_ready_o;
      waitCycle();
      if (did_push) push_idx++;
      if (opcode_valid_o) begin
        if (got < 10) begin
          checkOutput($sformatf("wrap%0d_pc", got), 32'(opcode_pc_o), 32'h0202 + 32'(2 * got));
          checkOutput($sformatf("wrap%0d_instr", got), 32'(opcode_instr_o), 32'h3000 | 32'(got + 1));
        end
        got++;
      end
    end
    checkOutput("wrap_count", 32'(got), 32'd10);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
